sbus_mem_responder: RTL

- Memory-side (responder) end of the SBUS request protocol issued by the MBOX: one simulated core memory module.
- Accepts START/RD RQ/WR RQ/quad-word RQ mask plus address, and returns the ACKN pulse, per-word DATA VALID strobes and error indications that the MBOX NXM timer and MB loading logic consume.
- Out-of-range addresses get no ACKN, so the MBOX NXM counter times out.
- Used as the memory model in EBOX/MBOX system benches.

---
 rtl/sbus_mem_responder_if.sv | 34 +++
 rtl/sbus_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sbus_mem_responder_if.sv
// SBUS request/response bundle between an MBOX requester and a memory responder.
// master: drives START_A/B, RD_RQ, WR_RQ, RQ[0:3], ADR[14:35], ADR_PAR,
//         DATA_IN[0:35], DATA_IN_PAR and ERR_CLR; receives the response signals.
// slave : receives the request signals; drives ACKN, DATA_VALID,
//         DATA_OUT[0:35], DATA_OUT_PAR, ADR_PAR_ERR, MEM_ERROR and BUSY.
interface sbus_mem_responder_if;
  logic        START_A;
  logic        START_B;
  logic        RD_RQ;
  logic        WR_RQ;
  logic [0:3]  RQ;
  logic [14:35] ADR;
  logic        ADR_PAR;
  logic [0:35] DATA_IN;
  logic        DATA_IN_PAR;
  logic        ERR_CLR;
  logic        ACKN;
  logic        DATA_VALID;
  logic [0:35] DATA_OUT;
  logic        DATA_OUT_PAR;
  logic        ADR_PAR_ERR;
  logic        MEM_ERROR;
  logic        BUSY;

  modport master (
    output START_A, START_B, RD_RQ, WR_RQ, RQ, ADR, ADR_PAR, DATA_IN, DATA_IN_PAR, ERR_CLR,
    input  ACKN, DATA_VALID, DATA_OUT, DATA_OUT_PAR, ADR_PAR_ERR, MEM_ERROR, BUSY
  );

  modport slave (
    input  START_A, START_B, RD_RQ, WR_RQ, RQ, ADR, ADR_PAR, DATA_IN, DATA_IN_PAR, ERR_CLR,
    output ACKN, DATA_VALID, DATA_OUT, DATA_OUT_PAR, ADR_PAR_ERR, MEM_ERROR, BUSY
  );
endinterface

// File: rtl/sbus_mem_responder.sv
// Simulated core memory module answering SBUS quad-word requests.
// Ports:
//   clk   - module clock
//   RESET - asynchronous active-high reset (memory contents are preserved)
//   bus   - sbus_mem_responder_if.slave: request inputs, ACKN / DATA_VALID /
//           DATA_OUT / parity and error outputs, BUSY
// Out-of-range requests get no answer so the requester's NXM timer expires.
// All outputs are registered; the state register is cycle-aligned with the
// outputs, so ACKN is shown in the last ACKWAIT cycle and every READ/WRITE
// cycle carries one DATA_VALID strobe.
module sbus_mem_responder #(
  parameter int unsigned BASE       = 0,
  parameter int unsigned WORDS      = 4096,
  parameter int unsigned ACK_DLY    = 2,
  parameter int unsigned ACCESS_DLY = 4
) (
  input logic                 clk,
  input logic                 RESET,
  sbus_mem_responder_if.slave bus
);

  localparam int unsigned AW = (WORDS > 4) ? $clog2(WORDS) : 2;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 36;

  // ACKWAIT lasts ACK_DLY cycles; ACCESS lasts ACCESS_DLY-1 cycles because
  // the ACKN cycle itself counts toward the access delay.
  localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_DLY - 1);
  localparam logic [CW-1:0] ACC_LOAD = CW'((ACCESS_DLY > 1) ? (ACCESS_DLY - 2) : 0);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACKWAIT = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;

  // Lowest set mask index (RQ[0] is served first).
  function automatic logic [1:0] first_idx(input logic [0:3] m);
    if (m[0])      first_idx = 2'd0;
    else if (m[1]) first_idx = 2'd1;
    else if (m[2]) first_idx = 2'd2;
    else           first_idx = 2'd3;
  endfunction

  function automatic logic [0:3] bit_of(input logic [1:0] i);
    bit_of = 4'b1000 >> i;
  endfunction

  logic [0:DW-1] mem [0:WORDS-1];

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] qbase_q, qbase_d;
  logic [0:3]    rq_q, rq_d;
  logic [0:3]    rem_q, rem_d;
  logic [1:0]    idx_q, idx_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          par_ok_q, par_ok_d;
  logic          ackn_q, ackn_d;
  logic          dv_q, dv_d;
  logic [0:DW-1] dout_q, dout_d;
  logic          dpar_q, dpar_d;
  logic          apar_err_q, apar_err_d;
  logic          mem_err_q, mem_err_d;
  logic          busy_q, busy_d;

  logic          start_c;
  logic [31:0]   off_c;
  logic          in_range_c;
  logic          din_ok_c;
  logic          we_c;
  logic [1:0]    first_rq_c;
  logic [1:0]    first_rem_c;
  logic [0:DW-1] rd_word_c;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    qbase_d    = qbase_q;
    rq_d       = rq_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    par_ok_d   = par_ok_q;
    mem_err_d  = mem_err_q & ~bus.ERR_CLR;
    we_c       = 1'b0;

    start_c     = (bus.START_A | bus.START_B) & (bus.RD_RQ | bus.WR_RQ);
    // Below-BASE addresses wrap to a huge offset and fail the single compare.
    off_c       = 32'(bus.ADR) - BASE;
    in_range_c  = off_c < WORDS;
    din_ok_c    = ^{bus.DATA_IN, bus.DATA_IN_PAR};
    first_rq_c  = first_idx(rq_q);
    first_rem_c = first_idx(rem_q);

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          rq_d     = bus.RQ;
          rd_d     = bus.RD_RQ;
          wr_d     = bus.WR_RQ;
          par_ok_d = ^{bus.ADR, bus.ADR_PAR};
          qbase_d  = AW'(off_c) & ~AW'(3);
          if (in_range_c) begin
            state_d = S_ACKWAIT;
            cnt_d   = ACK_LOAD;
          end
        end
      end
      S_ACKWAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!par_ok_q || rq_q == 4'b0000) begin
          state_d = S_IDLE;
        end else if (rd_q) begin
          if (ACCESS_DLY > 1) begin
            state_d = S_ACCESS;
            cnt_d   = ACC_LOAD;
          end else begin
            state_d = S_READ;
            idx_d   = first_rq_c;
            rem_d   = rq_q & ~bit_of(first_rq_c);
          end
        end else begin
          state_d = S_WRITE;
          idx_d   = first_rq_c;
          rem_d   = rq_q & ~bit_of(first_rq_c);
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_READ;
          idx_d   = first_rq_c;
          rem_d   = rq_q & ~bit_of(first_rq_c);
        end
      end
      S_READ: begin
        if (rem_q != 4'b0000) begin
          idx_d = first_rem_c;
          rem_d = rem_q & ~bit_of(first_rem_c);
        end else if (wr_q) begin
          // Read-pause-write: write strobes follow the last read strobe directly.
          state_d = S_WRITE;
          idx_d   = first_rq_c;
          rem_d   = rq_q & ~bit_of(first_rq_c);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        // DATA_IN is taken on the edge that ends the current write strobe.
        we_c = din_ok_c;
        if (!din_ok_c) mem_err_d = 1'b1;
        if (rem_q != 4'b0000) begin
          idx_d = first_rem_c;
          rem_d = rem_q & ~bit_of(first_rem_c);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_word_c  = mem[qbase_d | AW'(idx_d)];
    ackn_d     = (state_d == S_ACKWAIT) && (cnt_d == '0) && par_ok_d;
    apar_err_d = (state_d == S_ACKWAIT) && (cnt_d == '0) && !par_ok_d;
    dv_d       = (state_d == S_READ) || (state_d == S_WRITE);
    dout_d     = (state_d == S_READ) ? rd_word_c : '0;
    dpar_d     = (state_d == S_READ) ? ~^rd_word_c : 1'b0;
    busy_d     = state_d != S_IDLE;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      qbase_q    <= '0;
      rq_q       <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      par_ok_q   <= 1'b0;
      ackn_q     <= 1'b0;
      dv_q       <= 1'b0;
      dout_q     <= '0;
      dpar_q     <= 1'b0;
      apar_err_q <= 1'b0;
      mem_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qbase_q    <= qbase_d;
      rq_q       <= rq_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      par_ok_q   <= par_ok_d;
      ackn_q     <= ackn_d;
      dv_q       <= dv_d;
      dout_q     <= dout_d;
      dpar_q     <= dpar_d;
      apar_err_q <= apar_err_d;
      mem_err_q  <= mem_err_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array; not reset, and write enable is only live in WRITE.
  always_ff @(posedge clk) begin
    if (we_c) mem[qbase_q | AW'(idx_q)] <= bus.DATA_IN;
  end

  assign bus.ACKN         = ackn_q;
  assign bus.DATA_VALID   = dv_q;
  assign bus.DATA_OUT     = dout_q;
  assign bus.DATA_OUT_PAR = dpar_q;
  assign bus.ADR_PAR_ERR  = apar_err_q;
  assign bus.MEM_ERROR    = mem_err_q;
  assign bus.BUSY         = busy_q;

endmodule
